imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot-time controller that loads the instruction memory from a byte stream before the core runs.
- Assembles little-endian bytes into 32-bit words and drives the IMEM write port.
- Pads every unloaded word with the halt instruction 32'h00000063 (beq x0,x0,0).
- Holds the single-cycle core in reset until the image is complete, then releases it.
- Sits between the host byte source (UART RX or testbench) and the IMEM/core.

Parameters:
- IMEM_DEPTH, 128, number of 32-bit instruction words; valid word indices are 0..IMEM_DEPTH-1.
- FILL_WORD, 32'h00000063, word written to unloaded locations.
- IDX_W, 8, width of the word-index and length fields; must satisfy 2**IDX_W >= IMEM_DEPTH.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- load_start, input, 1, single-cycle request to begin a load.
- load_len, input, IDX_W+1, number of words to load; sampled when load_start is accepted.
- rx_valid, input, 1, byte available on rx_data.
- rx_data, input, 8, byte payload.
- rx_ready, output, 1, loader accepts a byte this cycle.
- mem_we, output, 1, IMEM write strobe for one word.
- mem_waddr, output, IDX_W, word index of the write (byte address = mem_waddr<<2).
- mem_wdata, output, 32, write data.
- cpu_hold, output, 1, holds the core in reset; 1 while loading.
- load_done, output, 1, image complete and core released.
- load_err, output, 1, sticky flag for an illegal length request.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, rx_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0. Byte count and word count are 0.
- States: IDLE, RECV, FILL, RUN.
- IDLE (cpu_hold=1):
  - load_start with 1 <= load_len <= IMEM_DEPTH: latch len, clear counters and load_err, go to RECV.
  - load_start with load_len=0 or load_len>IMEM_DEPTH: set load_err=1, stay in IDLE.
- RECV:
  - rx_ready=1 combinationally while in RECV.
  - Each handshake (rx_valid&&rx_ready) places byte k (k=0..3) into bits [8k+7:8k] of the assembly register.
  - On the 4th byte: in the next cycle mem_we=1 for exactly one cycle, mem_waddr=word_cnt, mem_wdata=assembled word. word_cnt then increments.
  - When the word just written is index len-1: go to FILL if len<IMEM_DEPTH, else go to RUN.
  - Back-to-back bytes are accepted every cycle; rx_valid gaps of any length are tolerated.
- FILL:
  - rx_ready=0.
  - One write per cycle: mem_we=1, mem_wdata=FILL_WORD, mem_waddr runs from len to IMEM_DEPTH-1.
  - After the write to IMEM_DEPTH-1, go to RUN.
- RUN: cpu_hold=0, load_done=1, rx_ready=0, mem_we=0.
- load_start in RUN: reload. Apply the same length check as in IDLE.
  - Legal length: go to RECV; cpu_hold=1 and load_done=0 from the next cycle.
  - Illegal length: set load_err and stay in RUN.
- load_start in RECV or FILL: ignored.
- Bytes arriving when not in RECV: not accepted (rx_ready=0); the loader does not drop them internally.
- rst mid-load: return to IDLE and discard any partial word. Words already written are not restored.
- Counters never wrap: word_cnt is bounded by len, and the fill index is bounded by IMEM_DEPTH-1.
- At most one mem_we per cycle. Writes are strictly increasing in address with no gaps.

Decomposition:
- Shared package imem_pkg holds: IMEM_DEPTH, FILL_WORD, IDX_W, and the state enum (IDLE, RECV, FILL, RUN).
- The same IMEM_DEPTH constant feeds the fetch-side out-of-range check.
- One natural sub-module: byte_packer. It contains the 2-bit byte counter and 32-bit shift/assembly register, takes accept and byte inputs, and outputs word_valid and word.

Test Plan:
- Reset check: rst high 2 cycles -> cpu_hold=1, rx_ready=0, mem_we=0, load_done=0, load_err=0.
- Load len=2:
  - Stimulus: bytes 13 00 00 00 93 00 10 00, sent back-to-back.
  - Writes: [0]=00000013, [1]=00100093.
  - Then 126 fill writes of 00000063 at indices 2..127.
  - Then load_done=1 and cpu_hold=0; total mem_we count = 128.
- Full load: len=128 with incrementing words -> 128 data writes, no FILL writes, RUN entered the cycle after the write to [127].
- Illegal length: load_len=0, then load_len=129 -> load_err=1, state stays IDLE, no mem_we.
- Stalled source: len=1 with rx_valid toggling 1/0 over bytes AA BB CC DD -> single write [0]=DDCCBBAA; load_start pulsed during RECV has no effect.
- Reset and reload:
  - rst after 3 bytes -> no write occurs.
  - Then len=1 load -> word assembled from fresh bytes only.
  - Then load_start in RUN with len=1 -> cpu_hold reasserts and the second image is written.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared IMEM geometry, fill word and loader state encoding
package imem_pkg;
  localparam int IMEM_DEPTH = 128;
  localparam int IDX_W = 8;
  localparam logic [31:0] FILL_WORD = 32'h0000_0063;
  typedef enum logic [1:0] {IDLE, RECV, FILL, RUN} state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four little-endian bytes into a word, flagging completion a cycle later
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0] cnt;
  // byte k lands in bits [8k+7:8k]; word_valid pulses once the fourth byte is in
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= accept && cnt == 2'd3;
      if (accept) begin
        word[{cnt, 3'b000} +: 8] <= data;
        cnt <= cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads IMEM from a byte stream, pads with halt words, then releases the core
module imem_boot_loader
  import imem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [IDX_W:0]   load_len,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_err
);
  state_t state, state_n;
  logic [IDX_W:0] len;
  logic [IDX_W-1:0] word_cnt;
  logic [31:0] word;
  logic word_valid, accept, idle_or_run, legal, start_ok, last_data, last_idx;
  assign accept = rx_valid && rx_ready;
  assign idle_or_run = state == IDLE || state == RUN;
  assign legal = load_len != '0 && load_len <= (IDX_W+1)'(IMEM_DEPTH);
  assign start_ok = load_start && legal && idle_or_run;
  assign last_data = {1'b0, word_cnt} == len - 1'b1;
  assign last_idx = word_cnt == IDX_W'(IMEM_DEPTH - 1);
  byte_packer u_packer (
    .clk(clk),
    .rst(rst),
    .clr(start_ok),
    .accept(accept),
    .data(rx_data),
    .word_valid(word_valid),
    .word(word)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state and write-port/handshake outputs; one counter serves data and fill addresses
  always_comb begin
    state_n = start_ok ? RECV : state;
    rx_ready = state == RECV;
    mem_we = state == FILL || (state == RECV && word_valid);
    mem_waddr = state == RECV || state == FILL ? word_cnt : '0;
    mem_wdata = state == FILL ? FILL_WORD : state == RECV ? word : '0;
    cpu_hold = state != RUN;
    load_done = state == RUN;
    if (state == RECV && word_valid && last_data)
      state_n = len < (IDX_W+1)'(IMEM_DEPTH) ? FILL : RUN;
    if (state == FILL && last_idx) state_n = RUN;
  end
  // length latch, word/fill counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      len <= '0;
      word_cnt <= '0;
      load_err <= 1'b0;
    end else if (start_ok) begin
      len <= load_len;
      word_cnt <= '0;
      load_err <= 1'b0;
    end else begin
      if (load_start && idle_or_run) load_err <= 1'b1;
      if (mem_we && !last_idx) word_cnt <= word_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized self-checking bench against an image-level reference model
module tb_imem_boot_loader;
  import imem_pkg::*;
  logic clk = 0, rst = 1, load_start = 0, rx_valid = 0;
  logic [IDX_W:0] load_len = '0;
  logic [7:0] rx_data = '0;
  logic rx_ready, mem_we, cpu_hold, load_done, load_err;
  logic [IDX_W-1:0] mem_waddr;
  logic [31:0] mem_wdata;
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] bq[$];
  int wa[$], wc[$], ec[$];
  logic [31:0] wd[$];

  imem_boot_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_we) begin
    wa.push_back(int'(mem_waddr));
    wd.push_back(mem_wdata);
    wc.push_back(cyc);
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); ec.delete();
  endtask

  task automatic pulse(input int len);
    @(negedge clk);
    load_start = 1;
    load_len = (IDX_W+1)'(len);
    @(negedge clk);
    load_start = 0;
  endtask

  task automatic send_bytes(input int gap, input bit poke);
    int i = 0, t = 0;
    bit on = 0;
    while (i < bq.size() && t < 20000) begin
      @(negedge clk);
      load_start = poke && i == 2;
      load_len = (IDX_W+1)'(5);
      on = gap < 0 ? !on : $urandom_range(99) >= gap;
      rx_valid = on;
      rx_data = on ? bq[i] : 8'($urandom_range(255));
      if (rx_valid && rx_ready) begin
        if (i % 4 == 3) ec.push_back(cyc + 1);
        i++;
      end
      t++;
    end
    @(negedge clk);
    rx_valid = 0;
    load_start = 0;
    tests++;
    if (i != bq.size()) begin
      fails++;
      $display("FAIL bytes: accepted %0d, required %0d", i, bq.size());
    end
  endtask

  task automatic check_image(input int len);
    int t = 0, bad = -1, tbad = 0, done_cyc;
    logic [31:0] exp;
    while (!load_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    done_cyc = cyc;
    tests++;
    if (load_done !== 1'b1) begin
      fails++;
      $display("FAIL done_timeout: load_done=%b after %0d cycles, required 1", load_done, t);
    end
    tests++;
    if (wa.size() != IMEM_DEPTH) begin
      fails++;
      $display("FAIL write_count: got %0d writes, required %0d (len=%0d)", wa.size(), IMEM_DEPTH, len);
    end else begin
      for (int k = 0; k < IMEM_DEPTH; k++) begin
        exp = k < len ? {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]} : FILL_WORD;
        if (bad < 0 && (wa[k] != k || wd[k] !== exp)) bad = k;
      end
      tests++;
      if (bad >= 0) begin
        fails++;
        exp = bad < len ? {bq[4*bad+3], bq[4*bad+2], bq[4*bad+1], bq[4*bad]} : FILL_WORD;
        $display("FAIL image: write #%0d got [%0d]=%h, required [%0d]=%h", bad, wa[bad], wd[bad], bad, exp);
      end
      if (ec.size() != len) tbad = 1;
      for (int k = 0; k < IMEM_DEPTH && tbad == 0; k++)
        if (k < len ? wc[k] != ec[k] : wc[k] != wc[k-1] + 1) tbad = k + 2;
      if (done_cyc != wc[IMEM_DEPTH-1] + 1) tbad = -1;
      tests++;
      if (tbad != 0) begin
        fails++;
        $display("FAIL timing: code %0d, done at %0d, last write at %0d, required done one cycle after", tbad, done_cyc, wc[IMEM_DEPTH-1]);
      end
    end
    tests++;
    if (cpu_hold !== 1'b0 || load_err !== 1'b0 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL run_state: cpu_hold=%b load_err=%b rx_ready=%b, required 0 0 0", cpu_hold, load_err, rx_ready);
    end
  endtask

  task automatic do_load(input int len, input int gap, input bit poke);
    clear_log();
    pulse(len);
    tests++;
    if (rx_ready !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL start: rx_ready=%b cpu_hold=%b load_done=%b load_err=%b, required 1 1 0 0", rx_ready, cpu_hold, load_done, load_err);
    end
    send_bytes(gap, poke);
    check_image(len);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (cpu_hold !== 1'b1) begin fails++; $display("FAIL reset_hold: cpu_hold=%b, required 1", cpu_hold); end
    tests++;
    if (rx_ready !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL reset_port: rx_ready=%b mem_we=%b, required 0 0", rx_ready, mem_we); end
    tests++;
    if (load_done !== 1'b0 || load_err !== 1'b0) begin fails++; $display("FAIL reset_flags: load_done=%b load_err=%b, required 0 0", load_done, load_err); end
    tests++;
    if (mem_waddr !== '0 || mem_wdata !== '0) begin fails++; $display("FAIL reset_bus: addr=%h data=%h, required 0 0", mem_waddr, mem_wdata); end
    rst = 0;
  endtask

  task automatic test_illegal();
    clear_log();
    pulse(0);
    tests++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL illegal_zero: load_err=%b cpu_hold=%b rx_ready=%b, required 1 1 0", load_err, cpu_hold, rx_ready);
    end
    pulse(IMEM_DEPTH + 1);
    repeat (4) @(negedge clk);
    tests++;
    if (load_err !== 1'b1 || rx_ready !== 1'b0 || load_done !== 1'b0 || wa.size() != 0) begin
      fails++;
      $display("FAIL illegal_big: load_err=%b rx_ready=%b load_done=%b writes=%0d, required 1 0 0 0", load_err, rx_ready, load_done, wa.size());
    end
  endtask

  task automatic test_len2();
    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(2, 0, 0);
  endtask

  task automatic test_full();
    logic [31:0] w;
    bq.delete();
    for (int k = 0; k < IMEM_DEPTH; k++) begin
      w = 32'h1000_0000 + k;
      for (int b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
    end
    do_load(IMEM_DEPTH, 0, 0);
  endtask

  task automatic test_stall();
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(1, -1, 1);
  endtask

  task automatic test_reset_reload();
    clear_log();
    pulse(1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      rx_valid = 1;
      rx_data = 8'h77;
    end
    @(negedge clk);
    rx_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    tests++;
    if (wa.size() != 0 || cpu_hold !== 1'b1 || load_done !== 1'b0 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort: writes=%0d cpu_hold=%b load_done=%b rx_ready=%b, required 0 1 0 0", wa.size(), cpu_hold, load_done, rx_ready);
    end
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(1, 0, 0);
    bq = '{8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255))};
    do_load(1, 30, 0);
  endtask

  task automatic test_run_illegal();
    pulse(200);
    tests++;
    if (load_err !== 1'b1 || load_done !== 1'b1 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL run_illegal: load_err=%b load_done=%b cpu_hold=%b mem_we=%b, required 1 1 0 0", load_err, load_done, cpu_hold, mem_we);
    end
  endtask

  task automatic test_random();
    int len;
    repeat (4) begin
      len = $urandom_range(1, IMEM_DEPTH);
      bq.delete();
      for (int i = 0; i < 4 * len; i++) bq.push_back(8'($urandom_range(255)));
      do_load(len, $urandom_range(0, 60), 0);
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_len2();
    test_full();
    test_stall();
    test_reset_reload();
    test_run_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
